inv_diffusion_layer: RTL and testbench

INV_DIFFUSION_LAYER -- requirements
Module: inv_diffusion_layer

---
 rtl/ascon_pack.sv | 20 ++
 rtl/diffusion_layer.sv | 17 +
 rtl/inv_diffusion_round.sv | 23 ++
 rtl/inv_diffusion_layer.sv | 112 +++++++++++
 tb/tb_inv_diffusion_layer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/ascon_pack.sv
// Shared Ascon types and diffusion constants: 5x64-bit state, per-row rotation
// amounts, inverse round count, rotate helper and inverse-layer FSM encoding.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  localparam int unsigned NB_INV_ROUNDS = 6;
  localparam int unsigned ROT_A [0:4] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [0:4] = '{28, 39, 6, 17, 41};

  typedef enum logic [1:0] {IDLE, RUN, DONE} inv_state_t;

  // Doubled-word shift yields a rotate for any amount 0..63.
  function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] n);
    logic [127:0] t;
    t = {x, x} >> n;
    return t[63:0];
  endfunction

endpackage

// File: rtl/diffusion_layer.sv
// Ascon forward linear diffusion: per row x ^ ROTR(x,a) ^ ROTR(x,b).
module diffusion_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);

  always_comb begin
    state_o = '0;
    for (int unsigned r = 0; r < 5; r++) begin
      state_o[r] = state_i[r] ^ rotr64(state_i[r], 6'(ROT_A[r]))
                              ^ rotr64(state_i[r], 6'(ROT_B[r]));
    end
  end

endmodule

// File: rtl/inv_diffusion_round.sv
// One factor P_k of the inverse diffusion: rotation amounts doubled k times, mod 64.
module inv_diffusion_round
  import ascon_pack::*;
(
  input  type_state   state_i,
  input  logic [2:0]  k_i,
  output type_state   state_o
);

  logic [5:0] sh_a [0:4];
  logic [5:0] sh_b [0:4];

  always_comb begin
    state_o = '0;
    for (int unsigned r = 0; r < 5; r++) begin
      sh_a[r]    = 6'(ROT_A[r] << k_i);
      sh_b[r]    = 6'(ROT_B[r] << k_i);
      state_o[r] = state_i[r] ^ rotr64(state_i[r], sh_a[r])
                              ^ rotr64(state_i[r], sh_b[r]);
    end
  end

endmodule

// File: rtl/inv_diffusion_layer.sv
// Iterative inverse Ascon diffusion (Sigma^63 as six P_k passes, one per clock).
// Optional INV_DIFF_CHECK_EN re-applies the forward layer and flags mismatches on err_o.
module inv_diffusion_layer
  import ascon_pack::*;
(
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  type_state data_i,
  output type_state data_o,
  output logic      done_o,
`ifdef INV_DIFF_CHECK_EN
  output logic      busy_o,
  output logic      err_o
`else
  output logic      busy_o
`endif
);

  inv_state_t state_q, state_d;
  logic [2:0] k_q, k_d;
  type_state  data_q, data_d;
  type_state  round_in, round_out;
  logic [2:0] round_k;
  logic       start_take;

  // A start shares the single round instance: P_0 is applied straight to data_i.
  always_comb begin
    start_take = (state_q != RUN) && start_i;
    round_in   = start_take ? data_i : data_q;
    round_k    = start_take ? 3'd0 : k_q;
  end

  inv_diffusion_round u_round (
    .state_i (round_in),
    .k_i     (round_k),
    .state_o (round_out)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_take) begin
          data_d  = round_out;
          k_d     = 3'd1;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        data_d = round_out;
        k_d    = k_q + 3'd1;
        if (k_q == 3'(NB_INV_ROUNDS - 1)) begin
          k_d     = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
    data_o = data_q;
  end

`ifdef INV_DIFF_CHECK_EN
  type_state ref_q, ref_d;
  type_state fwd;
  logic      err_q, err_d;

  diffusion_layer u_fwd (
    .state_i (data_q),
    .state_o (fwd)
  );

  always_comb begin
    ref_d = start_take ? data_i : ref_q;
    err_d = err_q | ((state_q == DONE) && (fwd != ref_q));
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ref_q <= '0;
      err_q <= 1'b0;
    end else begin
      ref_q <= ref_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_inv_diffusion_layer.sv
// Directed self-checking bench for inv_diffusion_layer; expected values come
// from an independent forward-diffusion model (inverse checked by round trip).
module tb_inv_diffusion_layer;
  import ascon_pack::*;

  logic      clock_i = 1'b0;
  logic      reset_i = 1'b1;
  logic      start_i = 1'b0;
  type_state data_i  = '0;
  type_state data_o;
  logic      done_o, busy_o;
`ifdef INV_DIFF_CHECK_EN
  logic      err_o;
`endif

  inv_diffusion_layer dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .done_o  (done_o),
`ifdef INV_DIFF_CHECK_EN
    .busy_o  (busy_o),
    .err_o   (err_o)
`else
    .busy_o  (busy_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  int errors = 0;
  int checks = 0;

  int unsigned ta [0:4] = '{19, 61, 1, 10, 7};
  int unsigned tb [0:4] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    if (n == 0) return x;
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state sigma(input type_state x);
    type_state y;
    for (int r = 0; r < 5; r++) y[r] = x[r] ^ ror(x[r], ta[r]) ^ ror(x[r], tb[r]);
    return y;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Drive one start pulse, wait (bounded) for done_o, check latency and result.
  task automatic run_op(input string tag, input type_state din, input type_state exp);
    int n;
    data_i  = din;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, "_busy"}, 320'(busy_o), 320'(1));
    n = 1;
    while (!done_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 320'(n), 320'(6));
    chk({tag, "_data"}, data_o, exp);
  endtask

  type_state zero_s, ones_s, rt_x, rt_y;
  int busy_cnt;
  int done_seen;

  initial begin
    zero_s = '0;
    ones_s = '1;
    rt_x[0] = 64'h78e2_cc41_faab_aa1a;
    rt_x[1] = 64'hbc7a_2e77_5aab_abf7;
    rt_x[2] = 64'h4b81_c0cb_bdb5_fc1a;
    rt_x[3] = 64'hb22e_133e_424f_0250;
    rt_x[4] = 64'h044d_3370_2433_805d;
    rt_y = sigma(rt_x);

    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_data", data_o, '0);
    chk("rst_done", 320'(done_o), 320'(0));
    chk("rst_busy", 320'(busy_o), 320'(0));
`ifdef INV_DIFF_CHECK_EN
    chk("rst_err", 320'(err_o), 320'(0));
`endif

    run_op("zero", zero_s, zero_s);
    tick();
    chk("zero_idle_done", 320'(done_o), 320'(0));
    chk("zero_hold", data_o, zero_s);

    run_op("ones", ones_s, ones_s);
    tick();

    run_op("rt", rt_y, rt_x);
    tick();
    chk("rt_hold", data_o, rt_x);
`ifdef INV_DIFF_CHECK_EN
    chk("rt_err", 320'(err_o), 320'(0));
`endif

    // start held high through RUN with changing data: only the first capture counts
    data_i  = rt_y;
    start_i = 1'b1;
    tick();
    data_i  = ones_s;
    busy_cnt = 0;
    while (busy_o && busy_cnt < 20) begin
      busy_cnt++;
      tick();
    end
    start_i = 1'b0;
    chk("hold_busy_cycles", 320'(busy_cnt), 320'(5));
    chk("hold_done", 320'(done_o), 320'(1));
    chk("hold_data", data_o, rt_x);
    tick();

    // reset during round k=3 aborts the operation
    data_i  = rt_y;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("abort_data", data_o, '0);
    chk("abort_busy", 320'(busy_o), 320'(0));
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_o) done_seen++;
      tick();
    end
    chk("abort_no_done", 320'(done_seen), 320'(0));
    run_op("after_abort", rt_y, rt_x);

    // back-to-back: restart while DONE
    data_i  = rt_y;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("b2b_done_drop", 320'(done_o), 320'(0));
    chk("b2b_busy_rise", 320'(busy_o), 320'(1));
    begin
      int n;
      n = 1;
      while (!done_o && n < 20) begin
        tick();
        n++;
      end
      chk("b2b_lat", 320'(n), 320'(6));
      chk("b2b_data", data_o, rt_x);
    end
`ifdef INV_DIFF_CHECK_EN
    chk("b2b_err", 320'(err_o), 320'(0));
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
